// File: rtl/ps2_tx_pkg.sv
// Shared types and helpers for the device-side PS/2 transmitter.
package ps2_tx_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // On-wire frame, LSB transmitted first: start, data LSB..MSB, parity, stop.
  typedef struct packed {
    logic              stop;
    logic              par;
    logic [BYTE_W-1:0] data;
    logic              start;
  } frame_t;

  // Odd parity: total ones over data plus parity bit is odd.
  function automatic logic odd_parity(input logic [BYTE_W-1:0] d);
    return ~^d;
  endfunction

  function automatic frame_t make_frame(input logic [BYTE_W-1:0] d);
    frame_t f;
    f.stop  = 1'b1;
    f.par   = odd_parity(d);
    f.data  = d;
    f.start = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte queue with head re-insert (unpop) for retrying an aborted frame.
// If the queue is full when a byte is re-inserted, the newest byte is evicted and
// reported through drop_c.
module ps2_tx_fifo
  import ps2_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  input  logic              unpop,
  input  logic [BYTE_W-1:0] unpop_data,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              empty_next_c,
  output logic              drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, rd_ptr_m1;
  logic [CW-1:0]     count, count_n;
  logic              pop_ok, push_ok, evict;

  assign head      = mem[rd_ptr];
  assign rd_ptr_m1 = rd_ptr - AW'(1);

  // Accept/drop decision and next pointer/count values.
  always_comb begin
    pop_ok   = pop && !empty;
    evict    = unpop && full;
    push_ok  = unpop ? (push && (count < CW'(DEPTH - 1)))
                     : (push && (!full || pop_ok));
    drop_c   = (push && !push_ok) || evict;
    count_n  = count;
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    if (push_ok) begin
      count_n  = count_n + CW'(1);
      wr_ptr_n = wr_ptr_n + AW'(1);
    end
    if (pop_ok) begin
      count_n  = count_n - CW'(1);
      rd_ptr_n = rd_ptr_n + AW'(1);
    end
    if (unpop) begin
      rd_ptr_n = rd_ptr_m1;
      if (evict) wr_ptr_n = wr_ptr_n - AW'(1);
      else       count_n  = count_n + CW'(1);
    end
    empty_next_c = (count_n == '0);
  end

  // Storage; push and re-insert never target the same slot.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
    if (unpop)   mem[rd_ptr_m1] <= unpop_data;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      full   <= (count_n == CW'(DEPTH));
      empty  <= (count_n == '0);
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: queues bytes and clocks them out as 11-bit frames.
// Optional macro PS2_TX_INHIBIT_EN adds host_inhibit (defer/abort with retry).
// GAP_BITS is expected to be >= 1.
module ps2_kbd_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HALF_BIT   = 2000,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              wr,
  input  logic [BYTE_W-1:0] din,
  output logic              full,
  output logic              busy,
  output logic              overflow,
  output logic              ps2_clk,
  output logic              ps2_data
`ifdef PS2_TX_INHIBIT_EN
  ,
  input  logic              host_inhibit
`endif
);

  localparam int unsigned HW         = $clog2(HALF_BIT);
  localparam int unsigned GAP_HALVES = 2 * GAP_BITS;
  localparam int unsigned GW         = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  localparam logic [HW-1:0]    HALF_MAX = HW'(HALF_BIT - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_HALVES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  state_t                  state, state_n;
  logic [HW-1:0]           cnt, cnt_n;
  logic                    phase_b, phase_b_n;
  logic [IDX_W-1:0]        bit_idx, bit_idx_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic [GW-1:0]           gap_idx, gap_idx_n;
  logic                    pop_c, unpop_c, start_c, can_start;
  logic                    clk_c, data_c, busy_c;
  logic [BYTE_W-1:0]       head, retry_byte;
  logic                    empty, empty_next_c, drop_c;
  logic                    inhibit_s;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk_sys),
    .reset        (reset),
    .push         (wr),
    .din          (din),
    .pop          (pop_c),
    .unpop        (unpop_c),
    .unpop_data   (retry_byte),
    .head         (head),
    .full         (full),
    .empty        (empty),
    .empty_next_c (empty_next_c),
    .drop_c       (drop_c)
  );

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0]        inhibit_sync;
  logic [BYTE_W-1:0] cur_byte;

  // Two-flop synchroniser for the asynchronous host inhibit line.
  always_ff @(posedge clk_sys) begin
    if (reset) inhibit_sync <= 2'b00;
    else       inhibit_sync <= {inhibit_sync[0], host_inhibit};
  end

  // Keep the in-flight byte so an aborted frame can be put back at the head.
  always_ff @(posedge clk_sys) begin
    if (reset)      cur_byte <= '0;
    else if (pop_c) cur_byte <= head;
  end

  assign inhibit_s  = inhibit_sync[1];
  assign retry_byte = cur_byte;
`else
  assign inhibit_s  = 1'b0;
  assign retry_byte = head;
`endif

  // Next-state, counters and line levels; line levels are registered below.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    phase_b_n = phase_b;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    gap_idx_n = gap_idx;
    pop_c     = 1'b0;
    unpop_c   = 1'b0;
    start_c   = 1'b0;
    clk_c     = 1'b1;
    data_c    = 1'b1;
    can_start = !empty && !inhibit_s;

    unique case (state)
      IDLE: begin
        if (can_start) start_c = 1'b1;
      end
      BIT: begin
        clk_c  = !phase_b;
        data_c = shreg[0];
        if (inhibit_s && (bit_idx < LAST_IDX)) begin
          // Host took the line before the stop bit: release lines and retry later.
          unpop_c   = 1'b1;
          clk_c     = 1'b1;
          data_c    = 1'b1;
          state_n   = GAP;
          cnt_n     = HALF_MAX;
          phase_b_n = 1'b0;
          gap_idx_n = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - HW'(1);
        end else begin
          cnt_n = HALF_MAX;
          if (!phase_b) begin
            phase_b_n = 1'b1;
          end else begin
            phase_b_n = 1'b0;
            if (bit_idx == LAST_IDX) begin
              state_n   = GAP;
              gap_idx_n = '0;
            end else begin
              bit_idx_n = bit_idx + IDX_W'(1);
              shreg_n   = {1'b1, shreg[FRAME_BITS-1:1]};
            end
          end
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - HW'(1);
        end else begin
          cnt_n = HALF_MAX;
          if (gap_idx == GAP_LAST) begin
            // Chain straight into the next frame so the idle gap is exact.
            if (can_start) start_c = 1'b1;
            else           state_n = IDLE;
          end else begin
            gap_idx_n = gap_idx + GW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (start_c) begin
      pop_c     = 1'b1;
      shreg_n   = make_frame(head);
      bit_idx_n = '0;
      cnt_n     = HALF_MAX;
      phase_b_n = 1'b0;
      state_n   = BIT;
    end

    busy_c = (state_n != IDLE) || !empty_next_c;
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      phase_b  <= 1'b0;
      bit_idx  <= '0;
      shreg    <= '1;
      gap_idx  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase_b  <= phase_b_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      gap_idx  <= gap_idx_n;
      ps2_clk  <= clk_c;
      ps2_data <= data_c;
      busy     <= busy_c;
      overflow <= drop_c;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx (HALF_BIT=4, GAP_BITS=2, FIFO_DEPTH=16).
// Define PS2_TX_INHIBIT_EN to exercise the host inhibit path.
module tb_ps2_kbd_tx;

  localparam int unsigned HB = 4;
  localparam int unsigned GB = 2;
  localparam int unsigned FD = 16;
  localparam int FRAME_LEN = 88;
  localparam int GAP_LEN   = 16;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       wr      = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       full, busy, overflow, ps2_clk, ps2_data;
`ifdef PS2_TX_INHIBIT_EN
  logic       host_inhibit = 1'b0;
`endif

  ps2_kbd_tx #(.FIFO_DEPTH(FD), .HALF_BIT(HB), .GAP_BITS(GB)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .wr       (wr),
    .din      (din),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
`ifdef PS2_TX_INHIBIT_EN
    ,
    .host_inhibit (host_inhibit)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [10:0] frame;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Monitor state
  logic        prev_clk  = 1'b1;
  logic        prev_data = 1'b1;
  logic        in_frame  = 1'b0;
  logic        track_gap = 1'b0;
  logic [10:0] rx        = '0;
  int          bit_cnt   = 0;
  int          start_cyc = 0;
  int          hi_run    = 0;
  int          hh        = 0;
  int          fall_cnt  = 0;
  int          ovf_cnt   = 0;
  int          abort_cnt = 0;
  exp_t        e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: rebuilds frames from falling ps2_clk edges and scores them.
  always @(negedge clk_sys) begin
    if (overflow) ovf_cnt++;
    if (prev_clk && !ps2_clk) fall_cnt++;
    if (reset) begin
      in_frame  = 1'b0;
      bit_cnt   = 0;
      track_gap = 1'b0;
      exp_q.delete();
    end else begin
      if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
        if (track_gap && exp_q.size() > 0 && exp_q[0].gap >= 0)
          chk("gap_cycles", hh, exp_q[0].gap);
        track_gap = 1'b0;
        in_frame  = 1'b1;
        bit_cnt   = 0;
        rx        = '0;
        start_cyc = cyc;
        hi_run    = 0;
      end
      if (in_frame) begin
        if (prev_clk && !ps2_clk) begin
          rx = {ps2_data, rx[10:1]};
          bit_cnt++;
        end
        hi_run = ps2_clk ? hi_run + 1 : 0;
        if (bit_cnt == 11 && !prev_clk && ps2_clk) begin
          chk("frame_len", cyc - start_cyc, FRAME_LEN);
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", int'(rx), -1);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", int'(rx), int'(e.frame));
          end
          in_frame  = 1'b0;
          track_gap = 1'b1;
          hh        = 0;
        end else if (hi_run > int'(HB) + 1) begin
          abort_cnt++;
          in_frame  = 1'b0;
          track_gap = 1'b0;
        end
      end
      if (!in_frame && track_gap && ps2_clk && ps2_data) hh++;
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_exp(input logic [10:0] f, input int gap);
    exp_t x;
    x.frame = f;
    x.gap   = gap;
    exp_q.push_back(x);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || in_frame || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain_in_budget"}, int'(n < budget), 1);
  endtask

  task automatic wait_bit(input int b, input int budget, input string name);
    int n = 0;
    while (!(in_frame && bit_cnt == b) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_reached_bit"}, int'(n < budget), 1);
  endtask

  initial begin
    int ovf0, f0, ab0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ps2_clk", int'(ps2_clk), 1);
    chk("rst_ps2_data", int'(ps2_data), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick();

    // 1: single byte 0x1C, latency and frame shape
    wr = 1'b1; din = 8'h1C;
    push_exp(11'h438, -1);
    tick();
    wr = 1'b0;
    chk("t1_busy_after_wr", int'(busy), 1);
    tick();
    chk("t1_data_n1", int'(ps2_data), 1);
    tick();
    chk("t1_data_n2_start", int'(ps2_data), 0);
    chk("t1_clk_n2", int'(ps2_clk), 1);
    repeat (3) tick();
    chk("t1_clk_n5", int'(ps2_clk), 1);
    tick();
    chk("t1_clk_n6_fall", int'(ps2_clk), 0);
    wait_idle(500, "t1");

    // 2: parity corners, back to back
    wr = 1'b1; din = 8'h00; push_exp(11'h600, -1); tick();
    din = 8'hFF; push_exp(11'h7FE, GAP_LEN); tick();
    din = 8'h01; push_exp(11'h402, GAP_LEN); tick();
    wr = 1'b0;
    wait_idle(1000, "t2");

    // 3: two frames, exact inter-frame gap
    wr = 1'b1; din = 8'hF0; push_exp(11'h7E0, -1); tick();
    din = 8'h1C; push_exp(11'h438, GAP_LEN); tick();
    wr = 1'b0;
    wait_idle(1000, "t3");

    // 4: 18 consecutive writes, one dropped
    ovf0 = ovf_cnt;
    for (int i = 0; i < 18; i++) begin
      logic [7:0] d;
      d = 8'h30 + 8'(i);
      if (i < 17) push_exp(mk(d), (i == 0) ? -1 : GAP_LEN);
      wr = 1'b1; din = d;
      tick();
    end
    wr = 1'b0;
    chk("t4_full_at_18th", int'(full), 1);
    chk("t4_overflow_pulse", int'(overflow), 1);
    tick();
    chk("t4_overflow_clears", int'(overflow), 0);
    tick();
    chk("t4_overflow_count", ovf_cnt - ovf0, 1);
    wait_idle(4000, "t4");
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_full_end", int'(full), 0);

    // 5: reset in bit 5 with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h11 * 8'(i + 1);
      push_exp(mk(d), -1);
      wr = 1'b1; din = d;
      tick();
    end
    wr = 1'b0;
    wait_bit(5, 300, "t5");
    reset = 1'b1;
    tick();
    chk("t5_clk_high", int'(ps2_clk), 1);
    chk("t5_data_high", int'(ps2_data), 1);
    chk("t5_busy_low", int'(busy), 0);
    chk("t5_full_low", int'(full), 0);
    reset = 1'b0;
    f0 = fall_cnt;
    repeat (300) tick();
    chk("t5_no_edges", fall_cnt - f0, 0);
    chk("t5_busy_stays_low", int'(busy), 0);
    chk("t5_no_pending", exp_q.size(), 0);

`ifdef PS2_TX_INHIBIT_EN
    // 6: abort in bit 3 with retry, then inhibit during stop bit ignored
    ab0 = abort_cnt;
    wr = 1'b1; din = 8'hAA; push_exp(11'h754, -1); tick();
    din = 8'h55; push_exp(11'h6AA, -1); tick();
    wr = 1'b0;
    wait_bit(3, 300, "t6a");
    host_inhibit = 1'b1;
    repeat (30) tick();
    chk("t6_abort_seen", abort_cnt - ab0, 1);
    chk("t6_lines_high_clk", int'(ps2_clk), 1);
    chk("t6_lines_high_data", int'(ps2_data), 1);
    chk("t6_both_pending", exp_q.size(), 2);
    host_inhibit = 1'b0;
    wait_bit(10, 500, "t6b");
    host_inhibit = 1'b1;
    repeat (40) tick();
    chk("t6_stop_no_abort", abort_cnt - ab0, 1);
    chk("t6_deferred", exp_q.size(), 1);
    host_inhibit = 1'b0;
    wait_idle(1000, "t6");
`else
    ab0 = abort_cnt;
    chk("no_aborts", ab0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
